// File: rtl/mips_multicycle_core_if.sv
// Unified instruction/data memory bus with a req/ready handshake.
// The core is the master; the memory (or bench model) is the slave.
interface mips_multicycle_core_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS32-subset core: FETCH/DECODE/EXEC/MEM/WB/TRAP over one memory port.
// Define MIPS_MMIO_EN to map PortIn/PortOut into the MMIO_BASE window.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC      = 32'h0040_0000,
  parameter int unsigned PORT_IN_WIDTH = 8,
  parameter logic [31:0] MMIO_BASE     = 32'hFFFF_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  mips_multicycle_core_if.master   mem,
  input  logic [PORT_IN_WIDTH-1:0] PortIn,
  output logic [31:0]              PortOut,
  output logic [31:0]              ALUResultOut,
  output logic                     instr_retired,
  output logic                     trap
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} stateT;

  stateT       state;
  logic [31:0] pc, ir, regA, regB, branchTarget, mdr;
  logic [31:0] regs [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, wbDst;
  logic [31:0] immSext, immZext, aluRes, wbData;
  logic        legal, isStore, mmioHit;

  assign opcode  = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign shamt   = ir[10:6];
  assign funct   = ir[5:0];
  assign immSext = {{16{ir[15]}}, ir[15:0]};
  assign immZext = {16'h0000, ir[15:0]};
  assign isStore = (opcode == 6'h2B);
  assign wbDst   = (opcode == 6'h00) ? rd : rt;
  assign wbData  = (opcode == 6'h23) ? mdr : ALUResultOut;

`ifdef MIPS_MMIO_EN
  assign mmioHit = (ALUResultOut[31:16] == MMIO_BASE[31:16]);
`else
  logic unusedPortIn;
  assign unusedPortIn = ^PortIn;
  assign mmioHit      = 1'b0;
  assign PortOut      = '0;
`endif

  always_comb begin
    aluRes = '0;
    legal  = 1'b1;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20:   aluRes = regA + regB;
          6'h22:   aluRes = regA - regB;
          6'h24:   aluRes = regA & regB;
          6'h25:   aluRes = regA | regB;
          6'h27:   aluRes = ~(regA | regB);
          6'h2A:   aluRes = {31'b0, $signed(regA) < $signed(regB)};
          6'h00:   aluRes = regB << shamt;
          6'h02:   aluRes = regB >> shamt;
          6'h08:   aluRes = regA;
          default: legal = 1'b0;
        endcase
      end
      6'h08, 6'h23, 6'h2B: aluRes = regA + immSext;
      6'h0C:               aluRes = regA & immZext;
      6'h0D:               aluRes = regA | immZext;
      6'h0F:               aluRes = {ir[15:0], 16'h0000};
      6'h0A:               aluRes = {31'b0, $signed(regA) < $signed(immSext)};
      6'h04, 6'h05:        aluRes = regA - regB;
      6'h02, 6'h03:        aluRes = pc;
      default:             legal = 1'b0;
    endcase
  end

  // The MEM address lives in ALUResultOut, so address/data stay stable across waits.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = pc;
    mem.mem_wdata = regB;
    if (reset) begin
      case (state)
        FETCH: mem.mem_req = (pc[1:0] == 2'b00);
        MEM: begin
          mem.mem_req  = (ALUResultOut[1:0] == 2'b00) && !mmioHit;
          mem.mem_we   = isStore;
          mem.mem_addr = ALUResultOut;
        end
        default: mem.mem_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      ir            <= '0;
      regA          <= '0;
      regB          <= '0;
      branchTarget  <= '0;
      mdr           <= '0;
      ALUResultOut  <= '0;
      instr_retired <= 1'b0;
      trap          <= 1'b0;
`ifdef MIPS_MMIO_EN
      PortOut       <= '0;
`endif
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      instr_retired <= 1'b0;
      case (state)
        FETCH: begin
          if (pc[1:0] != 2'b00) begin
            state <= TRAP;
            trap  <= 1'b1;
          end else if (mem.mem_ready) begin
            ir    <= mem.mem_rdata;
            pc    <= pc + 32'd4;
            state <= DECODE;
          end
        end
        DECODE: begin
          regA         <= regs[rs];
          regB         <= regs[rt];
          branchTarget <= pc + {immSext[29:0], 2'b00};
          state        <= EXEC;
        end
        EXEC: begin
          ALUResultOut <= aluRes;
          if (!legal) begin
            state <= TRAP;
            trap  <= 1'b1;
          end else begin
            case (opcode)
              6'h04, 6'h05: begin
                if ((regA == regB) == (opcode == 6'h04)) pc <= branchTarget;
                instr_retired <= 1'b1;
                state         <= FETCH;
              end
              6'h02, 6'h03: begin
                pc <= {pc[31:28], ir[25:0], 2'b00};
                if (opcode == 6'h03) regs[31] <= pc;
                instr_retired <= 1'b1;
                state         <= FETCH;
              end
              6'h23, 6'h2B: state <= MEM;
              6'h00: begin
                if (funct == 6'h08) begin
                  pc            <= regA;
                  instr_retired <= 1'b1;
                  state         <= FETCH;
                end else begin
                  state <= WB;
                end
              end
              default: state <= WB;
            endcase
          end
        end
        MEM: begin
          if (ALUResultOut[1:0] != 2'b00) begin
            state <= TRAP;
            trap  <= 1'b1;
          end else if (mmioHit) begin
`ifdef MIPS_MMIO_EN
            if (isStore) begin
              if (ALUResultOut == MMIO_BASE + 32'd4) PortOut <= regB;
              instr_retired <= 1'b1;
              state         <= FETCH;
            end else begin
              mdr   <= (ALUResultOut == MMIO_BASE) ? 32'(PortIn) : '0;
              state <= WB;
            end
`endif
          end else if (mem.mem_ready) begin
            if (isStore) begin
              instr_retired <= 1'b1;
              state         <= FETCH;
            end else begin
              mdr   <= mem.mem_rdata;
              state <= WB;
            end
          end
        end
        WB: begin
          if (wbDst != 5'd0) regs[wbDst] <= wbData;
          instr_retired <= 1'b1;
          state         <= FETCH;
        end
        default: trap <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core with a wait-state-programmable memory model.
module tb_mips_multicycle_core;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] IDLE     = 32'h1000FFFF;  // beq $0,$0,-1

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  PortIn;
  logic [31:0] PortOut, ALUResultOut;
  logic        instr_retired, trap;

  mips_multicycle_core_if bus();

  mips_multicycle_core #(
    .RESET_PC(RESET_PC),
    .PORT_IN_WIDTH(8),
    .MMIO_BASE(32'hFFFF_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem(bus),
    .PortIn(PortIn),
    .PortOut(PortOut),
    .ALUResultOut(ALUResultOut),
    .instr_retired(instr_retired),
    .trap(trap)
  );

  always #5 clk = ~clk;

  // Instruction space: 0x004xxxxx plus the 0x400 jump target; everything else is data.
  logic [31:0] imem [256];
  logic [31:0] dmem [512];
  int unsigned waitCycles = 0;
  int unsigned waitCnt    = 0;

  function automatic logic isImem(input logic [31:0] a);
    return (a[31:20] == 12'h004) || a[10];
  endfunction

  function automatic logic [7:0] imemIdx(input logic [31:0] a);
    return {a[10], a[8:2]};
  endfunction

  always_comb begin
    bus.mem_ready = bus.mem_req && (waitCnt >= waitCycles);
    bus.mem_rdata = isImem(bus.mem_addr) ? imem[imemIdx(bus.mem_addr)] : dmem[bus.mem_addr[10:2]];
  end

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ready) begin
      waitCnt <= 0;
      if (bus.mem_we && !isImem(bus.mem_addr)) dmem[bus.mem_addr[10:2]] <= bus.mem_wdata;
    end else if (bus.mem_req) begin
      waitCnt <= waitCnt + 1;
    end else begin
      waitCnt <= 0;
    end
  end

  int unsigned vecCount = 0;
  int unsigned missCount = 0;
  int unsigned dataReqs = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic loadProg(input logic [31:0] prog [8]);
    for (int i = 0; i < 256; i++) imem[i] = IDLE;
    for (int i = 0; i < 8; i++) imem[i] = prog[i];
  endtask

  task automatic startCore();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
  endtask

  // Counts negedges until the retire pulse; optionally checks held data-access address.
  task automatic waitRetire(input bit chkAddr, output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.mem_req && !isImem(bus.mem_addr)) begin
        dataReqs++;
        if (chkAddr) checkVal("dataAddrHold", bus.mem_addr, 32'd8);
      end
    end while (!instr_retired && n < 50);
    if (!instr_retired) checkVal("retireTimeout", n, 32'd0);
  endtask

  task automatic waitTrap(output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.mem_req && !isImem(bus.mem_addr)) dataReqs++;
    end while (!trap && n < 50);
    if (!trap) checkVal("trapTimeout", n, 32'd0);
  endtask

  initial begin
    logic [31:0] prog [8];
    int unsigned n, d0;
    logic reqSeen;
    reset  = 1'b0;
    PortIn = 8'hA5;

    // ALU and retire timing
    prog = '{32'h20010005, 32'h2002FFFD, 32'h00221820, IDLE, IDLE, IDLE, IDLE, IDLE};
    loadProg(prog);
    waitCycles = 0;
    repeat (2) @(negedge clk);
    checkVal("rstReq", bus.mem_req, 1'b0);
    checkVal("rstTrap", trap, 1'b0);
    checkVal("rstRetired", instr_retired, 1'b0);
    checkVal("rstAluOut", ALUResultOut, '0);
    checkVal("rstPortOut", PortOut, '0);
    startCore();
    checkVal("firstFetch", bus.mem_addr, RESET_PC);
    waitRetire(0, n); checkVal("addi1Cycles", n, 32'd4);
    waitRetire(0, n); checkVal("addi2Cycles", n, 32'd4);
    waitRetire(0, n); checkVal("addCycles", n, 32'd4);
    checkVal("reg3", dut.regs[3], 32'd2);
    checkVal("aluOut", ALUResultOut, 32'd2);

    // Load/store with two wait states on every request
    prog = '{32'h20030002, 32'hAC030008, 32'h8C040008, IDLE, IDLE, IDLE, IDLE, IDLE};
    loadProg(prog);
    waitCycles = 2;
    startCore();
    waitRetire(0, n); checkVal("addiWaitCycles", n, 32'd6);
    waitRetire(1, n); checkVal("swCycles", n, 32'd8);
    checkVal("dmemStore", dmem[2], 32'd2);
    waitRetire(1, n); checkVal("lwCycles", n, 32'd9);
    checkVal("reg4", dut.regs[4], 32'd2);

    // Branches
    prog = '{32'h20010007, 32'h20020007, 32'h10220002, 32'hFC000000,
             32'hFC000000, 32'h14220002, IDLE, IDLE};
    loadProg(prog);
    waitCycles = 0;
    startCore();
    waitRetire(0, n);
    waitRetire(0, n);
    waitRetire(0, n); checkVal("beqCycles", n, 32'd3);
    checkVal("beqTarget", bus.mem_addr, RESET_PC + 32'd20);
    waitRetire(0, n); checkVal("bneCycles", n, 32'd3);
    checkVal("bneFallThru", bus.mem_addr, RESET_PC + 32'd24);

    // jal, then reset during a lw wait state
    prog = '{32'h0C000100, IDLE, IDLE, IDLE, IDLE, IDLE, IDLE, IDLE};
    loadProg(prog);
    imem[128] = 32'h8C050000;
    waitCycles = 2;
    startCore();
    waitRetire(0, n); checkVal("jalCycles", n, 32'd5);
    checkVal("jalLink", dut.regs[31], RESET_PC + 32'd4);
    checkVal("jalTarget", bus.mem_addr, 32'h0000_0400);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.mem_req && !isImem(bus.mem_addr)) && n < 30);
    checkVal("lwReqSeen", {31'b0, bus.mem_req}, 32'd1);
    reset = 1'b0;
    #1 checkVal("reqDropOnReset", bus.mem_req, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checkVal("fetchAfterReset", bus.mem_addr, RESET_PC);
    checkVal("reg31Cleared", dut.regs[31], '0);

    // Traps: illegal opcode, then misaligned load
    prog = '{32'hFC000000, IDLE, IDLE, IDLE, IDLE, IDLE, IDLE, IDLE};
    loadProg(prog);
    waitCycles = 0;
    startCore();
    waitTrap(n); checkVal("illegalTrapCycles", n, 32'd3);
    reqSeen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      reqSeen = reqSeen | bus.mem_req;
    end
    checkVal("trapHeld", trap, 1'b1);
    checkVal("trapNoReq", reqSeen, 1'b0);
    prog = '{32'h8C010006, IDLE, IDLE, IDLE, IDLE, IDLE, IDLE, IDLE};
    loadProg(prog);
    startCore();
    d0 = dataReqs;
    waitTrap(n); checkVal("misalignTrapCycles", n, 32'd4);
    checkVal("misalignNoReq", dataReqs - d0, 32'd0);

    // MMIO window
    prog = '{32'h3C01FFFF, 32'h8C220000, 32'h34031234, 32'hAC230004, IDLE, IDLE, IDLE, IDLE};
    loadProg(prog);
    startCore();
    d0 = dataReqs;
    waitRetire(0, n);
    waitRetire(0, n); checkVal("mmioLwCycles", n, 32'd5);
    waitRetire(0, n);
    waitRetire(0, n); checkVal("mmioSwCycles", n, 32'd4);
`ifdef MIPS_MMIO_EN
    checkVal("mmioPortIn", dut.regs[2], 32'h0000_00A5);
    checkVal("mmioPortOut", PortOut, 32'h0000_1234);
    checkVal("mmioNoReq", dataReqs - d0, 32'd0);
`else
    checkVal("portOutTied", PortOut, '0);
    checkVal("noMmioReqs", dataReqs - d0, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
